// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative multiply/divide unit with HI/LO result registers
// One shift-add (MULT) or restoring subtract-shift (DIV) step per RUN cycle.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       Op,
  input  logic             Sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               is_div, neg_q, neg_r;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   sh, mb;

  logic               accept, zero_div, last;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum, shifted, trial, pick, acc_step;
  logic [WIDTH-1:0]   sh_step, quo, rem;
  logic [2*WIDTH-1:0] prod;

  assign accept   = (state == S_IDLE) && start;
  assign zero_div = (Op == OP_DIV) && (B == '0);
  assign last     = (cnt == CNT_W'(1));
  assign mag_a    = (Sign && A[WIDTH-1]) ? -A : A;
  assign mag_b    = (Sign && B[WIDTH-1]) ? -B : B;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (start)
        state_nxt = (Op == OP_MULT || (Op == OP_DIV && !zero_div)) ? S_RUN : S_FIN;
      S_RUN: begin
        busy = 1'b1;
        if (last) state_nxt = S_FIN;
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // acc doubles as the product high half (MULT) and the partial remainder (DIV);
  // sh is the multiplier being shifted out or the dividend/quotient shift register.
  always_comb begin
    sum     = acc + {1'b0, mb};
    shifted = {acc[WIDTH-1:0], sh[WIDTH-1]};
    trial   = shifted - {1'b0, mb};
    pick    = sh[0] ? sum : acc;
    if (is_div) begin
      acc_step = trial[WIDTH] ? shifted : trial;
      sh_step  = {sh[WIDTH-2:0], ~trial[WIDTH]};
    end else begin
      acc_step = {1'b0, pick[WIDTH:1]};
      sh_step  = {pick[0], sh[WIDTH-1:1]};
    end
    prod = {acc_step[WIDTH-1:0], sh_step};
    quo  = sh_step;
    rem  = acc_step[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      acc         <= '0;
      sh          <= '0;
      mb          <= '0;
      div_by_zero <= 1'b0;
      HI          <= '0;
      LO          <= '0;
    end else if (accept) begin
      cnt         <= CNT_W'(WIDTH);
      is_div      <= (Op == OP_DIV);
      neg_q       <= Sign && (A[WIDTH-1] ^ B[WIDTH-1]);
      neg_r       <= Sign && A[WIDTH-1];
      acc         <= '0;
      sh          <= mag_a;
      mb          <= mag_b;
      div_by_zero <= zero_div;
      case (Op)
        OP_MTHI: HI <= A;
        OP_MTLO: LO <= A;
        OP_DIV: if (zero_div) begin
          HI <= A;
          LO <= '1;
        end
        default: ;
      endcase
    end else if (state == S_RUN) begin
      acc <= acc_step;
      sh  <= sh_step;
      cnt <= cnt - CNT_W'(1);
      if (last) begin
        if (is_div) begin
          LO <= neg_q ? -quo : quo;
          HI <= neg_r ? -rem : rem;
        end else begin
          {HI, LO} <= neg_q ? -prod : prod;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - scoreboard bench for alu_muldiv with directed vectors
module tb_alu_muldiv;
  localparam int W = 32;
  localparam logic [1:0] MULT = 2'b00, DIV = 2'b01, MTHI = 2'b10, MTLO = 2'b11;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   Op = 2'b00;
  logic         Sign = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] HI, LO;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   bn;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .Op(Op), .Sign(Sign), .A(A), .B(B),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("HI", 64'(HI), 64'(e.hi));
        chk("LO", 64'(LO), 64'(e.lo));
        chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic sg, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] ehi,
                       input logic [W-1:0] elo, input logic edbz, input bit push);
    exp_t e;
    bit   lng;
    @(negedge clk);
    lng   = (op == MULT) || (op == DIV && b != '0);
    e.hi  = ehi;
    e.lo  = elo;
    e.dbz = edbz;
    e.cyc = cyc + (lng ? W + 1 : 1);
    if (push) q.push_back(e);
    start = 1'b1; Op = op; Sign = sg; A = a; B = b;
    @(negedge clk);
    start = 1'b0; A = ~a; B = ~b;
  endtask

  task automatic wait_done(output int busy_n);
    int n;
    n = 0;
    busy_n = 0;
    while (!done && n < 200) begin
      if (busy) busy_n++;
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_HI", 64'(HI), 64'd0);
    chk("rst_LO", 64'(LO), 64'd0);
    chk("rst_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
    reset = 1'b0;

    issue(MULT, 0, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 0, 1);
    wait_done(bn);
    chk("mult_busy_cycles", 64'(bn), 64'(W));
    issue(MULT, 1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, 1);
    wait_done(bn);
    issue(MULT, 0, 32'hFFFFFFFD, 32'h00000005, 32'h00000004, 32'hFFFFFFF1, 0, 1);
    wait_done(bn);
    issue(DIV, 1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 1);
    wait_done(bn);
    issue(DIV, 0, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 0, 1);
    wait_done(bn);
    chk("div_busy_cycles", 64'(bn), 64'(W));
    issue(DIV, 1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, 1);
    wait_done(bn);
    issue(DIV, 1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 1);
    wait_done(bn);
    issue(MULT, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 0, 1);
    wait_done(bn);

    issue(DIV, 0, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1, 1);
    wait_done(bn);
    chk("div0_busy_cycles", 64'(bn), 64'd0);
    @(negedge clk);
    chk("dbz_held_idle", 64'(div_by_zero), 64'd1);
    issue(MTHI, 0, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 32'hFFFFFFFF, 0, 1);
    wait_done(bn);
    issue(MTLO, 0, 32'h0000BEEF, 32'h0, 32'hCAFEF00D, 32'h0000BEEF, 0, 1);
    wait_done(bn);

    // DIV request on cycle 5 of a MULT must be dropped; operands also wiggle meanwhile.
    issue(MULT, 0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 0, 1);
    repeat (4) @(negedge clk);
    start = 1'b1; Op = DIV; Sign = 1'b1; A = 32'h5; B = 32'h0;
    @(negedge clk);
    start = 1'b0;
    wait_done(bn);
    repeat (3) @(negedge clk);

    issue(MULT, 0, 32'h00000003, 32'h00000003, 32'h0, 32'h0, 0, 0);
    repeat (9) @(negedge clk);
    chk("busy_before_reset", 64'(busy), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid_reset_HI", 64'(HI), 64'd0);
    chk("mid_reset_LO", 64'(LO), 64'd0);
    chk("mid_reset_flags", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);

    issue(MTLO, 0, 32'h00000005, 32'h0, 32'h00000000, 32'h00000005, 0, 1);
    wait_done(bn);
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
